// File: rtl/stream_arb_pkg.sv
// Shared types and limits for arbitrated stream blocks.
package stream_arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int MAX_CH = 16;
  localparam int MAX_DW = 64;

endpackage

// File: rtl/stream_arb_mux_if.sv
// Handshake bundle between N producers, the arbitrated mux and one consumer.
interface stream_arb_mux_if #(
  parameter int N_CH = 4,
  parameter int DW   = 8
);
  localparam int IDX_W = $clog2(N_CH);

  logic [N_CH-1:0]    in_valid;
  logic [N_CH*DW-1:0] in_data;
  logic [N_CH-1:0]    in_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [IDX_W-1:0]   out_sel;
  logic               out_ready;

  // Environment side: producers plus consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Mux side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin after last_ptr, or lowest index first.
module rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  arb_mode_e        mode,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;

  // NOTE: every output of an always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    // Round-robin first pass: channels strictly above last_ptr.
    for (int i = 0; i < N_CH; i++) begin
      if (mode == ARB_RR && !found && req[i] && i > int'(last_ptr)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    // Wrap-around for round-robin, and the whole search for fixed priority.
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel arbitrated stream mux with a single registered output stage.
module stream_arb_mux
  import stream_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  arb_mode_e mode,
  stream_arb_mux_if.slave bus
);

  if (N_CH < 2 || N_CH > MAX_CH) begin : g_bad_nch
    $error("stream_arb_mux: N_CH out of range");
  end
  if (DW < 1 || DW > MAX_DW) begin : g_bad_dw
    $error("stream_arb_mux: DW out of range");
  end

  logic [IDX_W-1:0] last_ptr;
  logic [N_CH-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic [DW-1:0]    sel_data;
  logic             load_en;
  logic             accept;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (bus.in_valid),
    .mode      (mode),
    .last_ptr  (last_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load_en      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = grant & {N_CH{load_en}};
  assign accept       = |bus.in_ready;

  // Grant is one-hot, so an AND-OR selects without a priority chain.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_data = sel_data | (bus.in_data[i*DW +: DW] & {DW{grant[i]}});
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      last_ptr      <= IDX_W'(N_CH - 1);
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= sel_data;
      bus.out_sel   <= grant_idx;
      last_ptr      <= grant_idx;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux with N_CH=4, DW=8.
module tb_stream_arb_mux;
  import stream_arb_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  arb_mode_e mode;
  int        checks = 0;
  int        errors = 0;

  stream_arb_mux_if #(.N_CH(4), .DW(8)) bus ();

  stream_arb_mux #(.N_CH(4), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic [1:0] s);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, "_data"},  32'(bus.out_data),  32'(d));
    check({tag, "_sel"},   32'(bus.out_sel),   32'(s));
  endtask

  logic [7:0] pat [4];

  initial begin
    pat[0] = 8'hA0; pat[1] = 8'hB1; pat[2] = 8'hC2; pat[3] = 8'hD3;

    // Reset then idle
    rst_n         = 1'b0;
    mode          = ARB_RR;
    bus.in_valid  = '0;
    bus.in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_out("reset", 1'b0, 8'h00, 2'd0);
    check("reset_ready", 32'(bus.in_ready), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check_out("idle", 1'b0, 8'h00, 2'd0);
      check("idle_ready", 32'(bus.in_ready), 32'h0);
    end

    // Round-robin fairness, all channels requesting
    bus.in_valid = 4'b1111;
    #1;
    check("rr_first_ready", 32'(bus.in_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step();
      check_out("rr", 1'b1, pat[k % 4], 2'(k % 4));
      check("rr_ready", 32'(bus.in_ready), 32'(1 << ((k + 1) % 4)));
    end

    // Backpressure: load B1 from channel 1, then stall
    bus.in_valid = 4'b0010;
    #1;
    check("bp_load_ready", 32'(bus.in_ready), 32'h2);
    step();
    check_out("bp_loaded", 1'b1, 8'hB1, 2'd1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_ready", 32'(bus.in_ready), 32'h0);
      step();
      check_out("bp_hold", 1'b1, 8'hB1, 2'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'h4);
    step();
    check_out("bp_release", 1'b1, 8'hC2, 2'd2);

    // Fixed priority: channels 1 and 3
    mode         = ARB_FIXED;
    bus.in_valid = 4'b1010;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("fix_ready", 32'(bus.in_ready), 32'h2);
      step();
      check_out("fix", 1'b1, 8'hB1, 2'd1);
    end
    bus.in_valid = 4'b1000;
    #1;
    check("fix_ch3_ready", 32'(bus.in_ready), 32'h8);
    step();
    check_out("fix_ch3", 1'b1, 8'hD3, 2'd3);

    // Sparse requests with wrap: move last_ptr to 2, then only channel 0
    mode         = ARB_RR;
    bus.in_valid = 4'b0100;
    #1;
    check("sp_ch2_ready", 32'(bus.in_ready), 32'h4);
    step();
    check_out("sp_ch2", 1'b1, 8'hC2, 2'd2);
    bus.in_valid = 4'b0001;
    #1;
    check("sp_wrap_ready", 32'(bus.in_ready), 32'h1);
    step();
    check_out("sp_wrap", 1'b1, 8'hA0, 2'd0);
    bus.in_valid = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      step();
      check("sp_idle_valid", 32'(bus.out_valid), 32'h0);
      check("sp_idle_ready", 32'(bus.in_ready), 32'h0);
    end
    // last_ptr must still be 0, so channel 1 wins next
    bus.in_valid = 4'b1111;
    #1;
    check("sp_keep_ptr_ready", 32'(bus.in_ready), 32'h2);
    step();
    check_out("sp_keep_ptr", 1'b1, 8'hB1, 2'd1);

    // Async reset between edges while holding a beat
    #1;
    rst_n = 1'b0;
    #1;
    check_out("arst", 1'b0, 8'h00, 2'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("arst_first_ready", 32'(bus.in_ready), 32'h1);
    step();
    check_out("arst_first", 1'b1, 8'hA0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_arb_mux.md
# stream_arb_mux

Parametrised N-channel, W-bit streaming multiplexer with per-channel valid/ready handshakes, hardware arbitration and a registered output stage. It replaces the fixed 4:1 single-bit combinational mux: the select signal is no longer driven externally but is produced by an internal round-robin or fixed-priority arbiter. It sits between several producers and one shared consumer, for example a bus or UART transmitter in the CPU-to-FPGA datapath.

## Interface
- `N_CH`, default 4: number of input channels, 2..16.
- `DW`, default 8: data width per channel, 1..64.
- `IDX_W`: derived localparam, not overridable; equals `$clog2(N_CH)`.

- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst_n`  in  1: reset; asynchronous assert, active-low.
- `mode`  in  1: arbitration mode; 0 = round-robin, 1 = fixed priority (lowest index wins).
- `in_valid`  in  N_CH: channel i offers a beat.
- `in_data`  in  N_CH*DW: channel i data occupies bits `[i*DW +: DW]`.
- `in_ready`  out  N_CH: channel i's beat is accepted this cycle.
- `out_valid`  out  1: output register holds a beat.
- `out_data`  out  DW: the held beat.
- `out_sel`  out  IDX_W: index of the channel that produced the held beat.
- `out_ready`  in  1: consumer accepts the beat.

## Operation
- The output register has two states.
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- The register loads when `load_en = !out_valid || out_ready`.
- Arbitration (combinational) produces a one-hot `grant` over requesting channels.
  - Round-robin: search starts at `last_ptr+1` modulo N_CH and takes the first set `in_valid`.
  - Fixed priority: takes the lowest-index set `in_valid`.
- `in_ready[i] = load_en && grant[i]`. At most one `in_ready` bit is set per cycle.
- Acceptance means `in_valid[i] && in_ready[i]`. On acceptance:
  - `out_data` ← channel i data, `out_sel` ← i, `out_valid` ← 1.
  - `last_ptr` ← i, in both modes.
- If the output is drained (`out_valid && out_ready`) with no acceptance in the same cycle, `out_valid` ← 0.
- Simultaneous drain and accept: `out_valid` stays 1 and the new beat replaces the old one. Full throughput is one beat per cycle.
- No requests: no load; `last_ptr` is unchanged.
- FULL with `out_ready`=0: all `in_ready`=0. `out_data` and `out_sel` are held stable until the beat is drained.
- A change of `mode` takes effect on the next arbitration. `last_ptr` is retained across mode changes.
- Producers must not make `in_valid` depend on `in_ready`. Once asserted, `in_valid` and its data stay stable until accepted.
- Arbitration is fair: in round-robin mode, with all channels requesting continuously, each channel is granted exactly once every N_CH accepted beats.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `last_ptr`=N_CH-1. The first round-robin grant goes to channel 0.
- Asserting reset mid-transfer discards the held beat immediately; it is not delivered.
- Latency: a beat accepted at edge k appears on `out_*` after edge k, visible in cycle k+1.
- `in_ready` is combinational from `in_valid`, `mode`, `out_valid` and `out_ready`. There is no combinational path from `in_data` to any output.
- `out_valid`, `out_data` and `out_sel` are driven directly from flops.

## Structure
- Shared package `stream_arb_pkg`:
  - `typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_e`.
  - Constants `MAX_CH = 16` and `MAX_DW = 64`, checked by elaboration-time assertions on the parameters.
- Sub-module `rr_arbiter #(N_CH)`:
  - Inputs: `req`, `mode`, `last_ptr`.
  - Outputs: one-hot `grant` and binary `grant_idx`.
  - Purely combinational; reused by later arbitrated blocks.
- The top level holds `last_ptr`, the output register and the data-select logic (an AND-OR of the one-hot `grant` with `in_data`).

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, then all `in_valid`=0 → `out_valid`=0, `out_data`=0, `out_sel`=0 and `in_ready`=0 throughout.
- Round-robin fairness: N_CH=4, DW=8, `mode`=0, `in_data` = {8'hD3, 8'hC2, 8'hB1, 8'hA0}, all channels valid, `out_ready`=1 → `out_sel` sequence 0,1,2,3,0,… and `out_data` A0,B1,C2,D3,A0,…, one beat per cycle.
- Fixed priority: `mode`=1, channels 1 and 3 valid → channel 1 is accepted every cycle and channel 3 sees `in_ready`=0. Dropping channel 1's `in_valid` → channel 3 is accepted next.
- Backpressure: output holding 8'hB1 from `out_sel`=1, `out_ready`=0 for 5 cycles → `out_data`/`out_sel` stay 8'hB1/1 and all `in_ready`=0. On the cycle `out_ready` rises, the next beat loads and `out_valid` stays 1.
- Sparse requests with wrap: `last_ptr`=2 and only channel 0 valid → `grant` goes to 0, skipping the idle channel 3, and `last_ptr` becomes 0. No requests for 10 cycles → `last_ptr` unchanged.
- Async reset mid-stream: assert `rst_n`=0 between clock edges while `out_valid`=1 → `out_valid` drops immediately. After release, the first round-robin grant goes to channel 0.
